// File: rtl/neuron_pkg.sv
// Shared widths and accumulator type for the neuron datapath, so the MAC,
// accumulator and activation stages agree on operand sizes.
package neuron_pkg;

  localparam int unsigned DIN_W  = 20;
  localparam int unsigned B_W    = 8;
  localparam int unsigned DOUT_W = 22;

  typedef logic signed [DOUT_W-1:0] acc_t;

endpackage : neuron_pkg

// File: rtl/sign_ext.sv
// Two's-complement sign extension from IN_W to OUT_W bits (OUT_W >= IN_W).
module sign_ext #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 22
) (
  input  logic [IN_W-1:0]  value,
  output logic [OUT_W-1:0] ext
);

  // A sized cast of a signed operand replicates the sign bit into the new MSBs.
  assign ext = OUT_W'($signed(value));

endmodule : sign_ext

// File: rtl/neuron_acc.sv
// Signed running-sum accumulator for one neuron: the bias is preloaded during
// reset, and one partial sum is added per clock, wrapping modulo 2^DOUT_W.
module neuron_acc
  import neuron_pkg::*;
#(
  parameter int unsigned DIN_W  = neuron_pkg::DIN_W,
  parameter int unsigned B_W    = neuron_pkg::B_W,
  parameter int unsigned DOUT_W = neuron_pkg::DOUT_W
) (
  input  logic [DIN_W-1:0]  din,
  input  logic [B_W-1:0]    b,
  input  logic              clk,
  input  logic              rst,
  output logic [DOUT_W-1:0] dout
);

  if (DOUT_W < DIN_W) begin : g_chk_din
    $error("neuron_acc: DOUT_W must be >= DIN_W");
  end
  if (DOUT_W < B_W) begin : g_chk_b
    $error("neuron_acc: DOUT_W must be >= B_W");
  end

  logic [DOUT_W-1:0] b_ext;
  logic [DOUT_W-1:0] din_ext;
  logic [DOUT_W-1:0] acc_q;

  sign_ext #(.IN_W(B_W), .OUT_W(DOUT_W)) u_ext_b (
    .value (b),
    .ext   (b_ext)
  );

  sign_ext #(.IN_W(DIN_W), .OUT_W(DOUT_W)) u_ext_din (
    .value (din),
    .ext   (din_ext)
  );

  // Reset reloads the bias; otherwise add every cycle with natural wraparound.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= b_ext;
    end else begin
      acc_q <= acc_q + din_ext;
    end
  end

  assign dout = acc_q;

endmodule : neuron_acc

// File: tb/tb_neuron_acc.sv
// Directed self-checking bench for neuron_acc: bias preload, accumulation,
// mid-run reset, negative bias, wraparound and bias isolation.
module tb_neuron_acc;

  localparam int unsigned DIN_W  = 20;
  localparam int unsigned B_W    = 8;
  localparam int unsigned DOUT_W = 22;

  logic              clk;
  logic              rst;
  logic [DIN_W-1:0]  din;
  logic [B_W-1:0]    b;
  logic [DOUT_W-1:0] dout;

  int checks = 0;
  int errors = 0;

  neuron_acc #(.DIN_W(DIN_W), .B_W(B_W), .DOUT_W(DOUT_W)) dut (
    .din  (din),
    .b    (b),
    .clk  (clk),
    .rst  (rst),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Apply inputs, take one rising edge, return at the following falling edge.
  task automatic step(input logic r, input int bias, input int d);
    rst = r;
    b   = B_W'(bias);
    din = DIN_W'(d);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 11, 0);
      checks++;
      if (dout !== DOUT_W'(11)) begin
        errors++;
        $display("FAIL reset_preload edge %0d: got %0d expected 11", i, $signed(dout));
      end
    end
    step(1'b0, 11, 0);
    checks++;
    if (dout !== DOUT_W'(11)) begin
      errors++;
      $display("FAIL reset_hold_zero_din: got %0d expected 11", $signed(dout));
    end
  endtask

  // The bias is flipped to 99 partway through; it must have no effect.
  task automatic test_accumulate();
    int d[9]   = '{1, 2, 3, 4, -3, 2, -5, 10, 10};
    int exp[9] = '{12, 14, 17, 21, 18, 20, 15, 25, 35};
    for (int i = 0; i < 9; i++) begin
      step(1'b0, (i >= 4) ? 99 : 11, d[i]);
      checks++;
      if (dout !== DOUT_W'(exp[i])) begin
        errors++;
        $display("FAIL accumulate step %0d: got %0d expected %0d", i, $signed(dout), exp[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    step(1'b1, 5, 1000);
    checks++;
    if (dout !== DOUT_W'(5)) begin
      errors++;
      $display("FAIL mid_reset_load: got %0d expected 5", $signed(dout));
    end
    step(1'b0, 5, -6);
    checks++;
    if (dout !== DOUT_W'(-1)) begin
      errors++;
      $display("FAIL mid_reset_add: got %0d expected -1", $signed(dout));
    end
  endtask

  task automatic test_negative_bias();
    step(1'b1, -128, 0);
    checks++;
    if (dout !== DOUT_W'(-128)) begin
      errors++;
      $display("FAIL neg_bias_load: got %0d expected -128", $signed(dout));
    end
    step(1'b0, -128, 100);
    checks++;
    if (dout !== DOUT_W'(-28)) begin
      errors++;
      $display("FAIL neg_bias_add: got %0d expected -28", $signed(dout));
    end
  endtask

  task automatic test_wrap();
    int exp[5] = '{524287, 1048574, 1572861, 2097148, -1572869};
    step(1'b1, 0, 0);
    checks++;
    if (dout !== DOUT_W'(0)) begin
      errors++;
      $display("FAIL wrap_preload: got %0d expected 0", $signed(dout));
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 0, 524287);
      checks++;
      if (dout !== DOUT_W'(exp[i])) begin
        errors++;
        $display("FAIL wrap step %0d: got %0d expected %0d", i, $signed(dout), exp[i]);
      end
    end
  endtask

  // Zero din holds the value even while the bias keeps changing.
  task automatic test_bias_isolation();
    int bias[3] = '{99, -7, 127};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, bias[i], 0);
      checks++;
      if (dout !== DOUT_W'(-1572869)) begin
        errors++;
        $display("FAIL bias_isolation %0d: got %0d expected -1572869", i, $signed(dout));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    b   = B_W'(11);
    din = '0;
    test_reset();
    test_accumulate();
    test_mid_reset();
    test_negative_bias();
    test_wrap();
    test_bias_isolation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_neuron_acc
